// File: rtl/isp_pkg.sv
// isp_pkg: shared ISP types and arithmetic helpers (FSM states, unity gain, saturating round-shift).
package isp_pkg;
    typedef enum logic [1:0] {WAIT_FRAME, ACCUM, UPDATE} ae_state_t;
    function automatic int unity_gain(input int frac);
        return 1 << frac;
    endfunction
    function automatic logic [31:0] sat_round_shift(input logic [31:0] prod, input int frac, input int out_w);
        logic [32:0] r;
        logic [32:0] lim;
        r = ({1'b0, prod} + ((frac > 0) ? (33'd1 << (frac - 1)) : 33'd0)) >> frac;
        lim = (33'd1 << out_w) - 33'd1;
        return (r > lim) ? lim[31:0] : r[31:0];
    endfunction
endpackage

// File: rtl/isp_roi_stats.sv
// isp_roi_stats: pixel/line counters, ROI hit test, and ROI luminance sum/count for one frame.
module isp_roi_stats #(
    parameter int DATA_W     = 8,
    parameter int X_W        = 11,
    parameter int Y_W        = 11,
    parameter int ROI_X0     = 384,
    parameter int ROI_Y0     = 256,
    parameter int ROI_W_LOG2 = 8,
    parameter int ROI_H_LOG2 = 8
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     clr,
    input  logic                                     en,
    input  logic                                     vsync,
    input  logic                                     hsync,
    input  logic                                     de,
    input  logic [DATA_W-1:0]                        img_y,
    output logic [DATA_W+ROI_W_LOG2+ROI_H_LOG2-1:0]  sum,
    output logic [ROI_W_LOG2+ROI_H_LOG2:0]           cnt
);
    localparam int SUM_W = DATA_W + ROI_W_LOG2 + ROI_H_LOG2;
    localparam logic [X_W:0] X_LO = (X_W+1)'(ROI_X0);
    localparam logic [X_W:0] X_HI = (X_W+1)'(ROI_X0 + (1 << ROI_W_LOG2));
    localparam logic [Y_W:0] Y_LO = (Y_W+1)'(ROI_Y0);
    localparam logic [Y_W:0] Y_HI = (Y_W+1)'(ROI_Y0 + (1 << ROI_H_LOG2));
    logic [X_W-1:0] x_cnt;
    logic [Y_W-1:0] y_cnt;
    logic           hs_d;
    logic           hit;
    always_comb begin
        hit = de & ({1'b0, x_cnt} >= X_LO) & ({1'b0, x_cnt} < X_HI)
                 & ({1'b0, y_cnt} >= Y_LO) & ({1'b0, y_cnt} < Y_HI);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_cnt <= '0;
            y_cnt <= '0;
            hs_d  <= 1'b0;
            sum   <= '0;
            cnt   <= '0;
        end else begin
            hs_d  <= hsync;
            x_cnt <= !hsync ? '0 : de ? x_cnt + 1'b1 : x_cnt;
            y_cnt <= vsync ? '0 : (hs_d & !hsync) ? y_cnt + 1'b1 : y_cnt;
            if (clr) begin
                sum <= '0;
                cnt <= '0;
            end else if (en & hit) begin
                sum <= sum + SUM_W'(img_y);
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/isp_auto_gain.sv
// isp_auto_gain: per-frame luminance auto-gain with ROI mean metering; define ISP_AE_MANUAL_GAIN_EN for manual gain override.
module isp_auto_gain
    import isp_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int X_W        = 11,
    parameter int Y_W        = 11,
    parameter int GAIN_W     = 8,
    parameter int GAIN_FRAC  = 6,
    parameter int GAIN_MIN   = 16,
    parameter int GAIN_MAX   = 255,
    parameter int GAIN_STEP  = 1,
    parameter int TARGET     = 128,
    parameter int HYST       = 8,
    parameter int ROI_X0     = 384,
    parameter int ROI_Y0     = 256,
    parameter int ROI_W_LOG2 = 8,
    parameter int ROI_H_LOG2 = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pre_frame_vsync,
    input  logic              pre_frame_hsync,
    input  logic              pre_frame_de,
    input  logic [DATA_W-1:0] img_y,
`ifdef ISP_AE_MANUAL_GAIN_EN
    input  logic              manual_en,
    input  logic [GAIN_W-1:0] manual_gain,
`endif
    output logic              post_frame_vsync,
    output logic              post_frame_hsync,
    output logic              post_frame_de,
    output logic [DATA_W-1:0] img_y_out,
    output logic [GAIN_W-1:0] cur_gain,
    output logic [DATA_W-1:0] frame_mean,
    output logic              mean_valid
);
    localparam int N_LOG2 = ROI_W_LOG2 + ROI_H_LOG2;
    localparam int SUM_W  = DATA_W + N_LOG2;
    localparam int LO_I   = (TARGET - HYST < 0) ? 0 : TARGET - HYST;
    localparam int HI_I   = (TARGET + HYST > (1 << DATA_W) - 1) ? (1 << DATA_W) - 1 : TARGET + HYST;
    localparam logic [DATA_W-1:0] LO     = DATA_W'(LO_I);
    localparam logic [DATA_W-1:0] HI     = DATA_W'(HI_I);
    localparam logic [GAIN_W-1:0] G_UNITY = GAIN_W'(unity_gain(GAIN_FRAC));
    localparam logic [GAIN_W:0]   G_MIN  = (GAIN_W+1)'(GAIN_MIN);
    localparam logic [GAIN_W:0]   G_MAX  = (GAIN_W+1)'(GAIN_MAX);
    localparam logic [GAIN_W:0]   G_STEP = (GAIN_W+1)'(GAIN_STEP);
    localparam logic [N_LOG2:0]   FULL   = {1'b1, {N_LOG2{1'b0}}};
    ae_state_t                state;
    logic [GAIN_W-1:0]        next_gain;
    logic [GAIN_W-1:0]        gain_up;
    logic [GAIN_W-1:0]        gain_dn;
    logic [GAIN_W-1:0]        gain_sel;
    logic [GAIN_W-1:0]        gain_load;
    logic                     freeze;
    logic                     vs_d;
    logic                     vs_fall;
    logic                     vs_rise;
    logic                     clr;
    logic                     vs1;
    logic                     hs1;
    logic                     de1;
    logic [DATA_W+GAIN_W-1:0] prod;
    logic [SUM_W-1:0]         sum;
    logic [N_LOG2:0]          cnt;
    logic [DATA_W-1:0]        mean;
    isp_roi_stats #(
        .DATA_W(DATA_W), .X_W(X_W), .Y_W(Y_W),
        .ROI_X0(ROI_X0), .ROI_Y0(ROI_Y0),
        .ROI_W_LOG2(ROI_W_LOG2), .ROI_H_LOG2(ROI_H_LOG2)
    ) u_stats (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(state == ACCUM),
        .vsync(pre_frame_vsync), .hsync(pre_frame_hsync), .de(pre_frame_de),
        .img_y(img_y), .sum(sum), .cnt(cnt)
    );
    always_comb begin
        vs_fall  = vs_d & ~pre_frame_vsync;
        vs_rise  = ~vs_d & pre_frame_vsync;
        clr      = (state == WAIT_FRAME) & vs_fall;
        mean     = DATA_W'(sum >> N_LOG2);
        gain_up  = ({1'b0, next_gain} + G_STEP > G_MAX) ? G_MAX[GAIN_W-1:0] : next_gain + G_STEP[GAIN_W-1:0];
        gain_dn  = ({1'b0, next_gain} < G_MIN + G_STEP) ? G_MIN[GAIN_W-1:0] : next_gain - G_STEP[GAIN_W-1:0];
        gain_sel = (mean < LO) ? gain_up : (mean > HI) ? gain_dn : next_gain;
`ifdef ISP_AE_MANUAL_GAIN_EN
        freeze    = manual_en;
        gain_load = !manual_en ? next_gain
                  : ({1'b0, manual_gain} < G_MIN) ? G_MIN[GAIN_W-1:0]
                  : ({1'b0, manual_gain} > G_MAX) ? G_MAX[GAIN_W-1:0] : manual_gain;
`else
        freeze    = 1'b0;
        gain_load = next_gain;
`endif
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= WAIT_FRAME;
            cur_gain         <= G_UNITY;
            next_gain        <= G_UNITY;
            vs_d             <= 1'b0;
            vs1              <= 1'b0;
            hs1              <= 1'b0;
            de1              <= 1'b0;
            prod             <= '0;
            post_frame_vsync <= 1'b0;
            post_frame_hsync <= 1'b0;
            post_frame_de    <= 1'b0;
            img_y_out        <= '0;
            frame_mean       <= '0;
            mean_valid       <= 1'b0;
        end else begin
            vs_d             <= pre_frame_vsync;
            vs1              <= pre_frame_vsync;
            hs1              <= pre_frame_hsync;
            de1              <= pre_frame_de;
            prod             <= {{GAIN_W{1'b0}}, img_y} * {{DATA_W{1'b0}}, cur_gain};
            post_frame_vsync <= vs1;
            post_frame_hsync <= hs1;
            post_frame_de    <= de1;
            img_y_out        <= de1 ? DATA_W'(sat_round_shift(32'(prod), GAIN_FRAC, DATA_W)) : '0;
            mean_valid       <= 1'b0;
            case (state)
                WAIT_FRAME: if (vs_fall) begin
                    cur_gain <= gain_load;
                    state    <= ACCUM;
                end
                ACCUM: if (vs_rise) state <= UPDATE;
                default: begin
                    // a truncated frame leaves mean and gain untouched
                    if (cnt == FULL) begin
                        frame_mean <= mean;
                        mean_valid <= 1'b1;
                        if (!freeze) next_gain <= gain_sel;
                    end
                    state <= WAIT_FRAME;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_isp_auto_gain.sv
// tb_isp_auto_gain: scoreboard bench for isp_auto_gain on 8x8 frames with a 4x4 ROI at (2,2).
module tb_isp_auto_gain;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       vsync;
    logic       hsync;
    logic       de;
    logic [7:0] img_y;
    logic       post_frame_vsync;
    logic       post_frame_hsync;
    logic       post_frame_de;
    logic [7:0] img_y_out;
    logic [7:0] cur_gain;
    logic [7:0] frame_mean;
    logic       mean_valid;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] e;
    int         m_cur;
    int         m_next;
    int         mv_cnt = 0;
    logic [7:0] mv_mean = 8'd0;

    always #5 clk = ~clk;

    isp_auto_gain #(
        .ROI_X0(2), .ROI_Y0(2), .ROI_W_LOG2(2), .ROI_H_LOG2(2), .GAIN_STEP(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .pre_frame_vsync(vsync), .pre_frame_hsync(hsync), .pre_frame_de(de), .img_y(img_y),
        .post_frame_vsync(post_frame_vsync), .post_frame_hsync(post_frame_hsync),
        .post_frame_de(post_frame_de), .img_y_out(img_y_out),
        .cur_gain(cur_gain), .frame_mean(frame_mean), .mean_valid(mean_valid)
    );

    function automatic logic [7:0] exp_px(input int y, input int g);
        int r;
        r = (y * g + 32) >> 6;
        return (r > 255) ? 8'd255 : 8'(r);
    endfunction

    always @(negedge clk) begin
        if (mean_valid) begin
            mv_cnt++;
            mv_mean = frame_mean;
        end
        if (post_frame_de) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pixel_extra got %0d with no pixel expected", img_y_out);
            end else begin
                e = exp_q.pop_front();
                if (img_y_out !== e) begin
                    errors++;
                    $display("FAIL pixel got %0d expected %0d", img_y_out, e);
                end
            end
        end else if (rst_n) begin
            checks++;
            if (img_y_out !== 8'd0) begin
                errors++;
                $display("FAIL idle_pixel got %0d expected 0", img_y_out);
            end
        end
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_line(input int yv, input int l, input bit pat, inout int roi_sum);
        int p;
        for (int x = 0; x < 8; x++) begin
            p = yv + (pat ? 8 * x + l : 0);
            hsync = 1'b1;
            de    = 1'b1;
            img_y = 8'(p);
            exp_q.push_back(exp_px(p, m_cur));
            if (x >= 2 && x < 6 && l >= 2 && l < 6) roi_sum += p;
            cyc;
        end
        hsync = 1'b0;
        de    = 1'b0;
        img_y = 8'd0;
        cyc;
        cyc;
    endtask

    task automatic run_frame(input int yv, input int lines, input bit pat);
        int roi_sum;
        int mean_exp;
        roi_sum = 0;
        vsync   = 1'b0;
        mv_cnt  = 0;
        cyc;
        cyc;
        m_cur = m_next;
        @(negedge clk);
        checks++;
        if (cur_gain !== 8'(m_cur)) begin
            errors++;
            $display("FAIL frame_gain got %0d expected %0d", cur_gain, m_cur);
        end
        cyc;
        for (int l = 0; l < lines; l++) drive_line(yv, l, pat, roi_sum);
        vsync = 1'b1;
        repeat (5) cyc;
        checks++;
        if (mv_cnt !== ((lines == 8) ? 1 : 0)) begin
            errors++;
            $display("FAIL mean_valid_pulses got %0d expected %0d", mv_cnt, (lines == 8) ? 1 : 0);
        end
        if (lines == 8) begin
            mean_exp = roi_sum >> 4;
            checks++;
            if (mv_mean !== 8'(mean_exp)) begin
                errors++;
                $display("FAIL frame_mean got %0d expected %0d", mv_mean, mean_exp);
            end
            if (mean_exp < 120) m_next = (m_next + 4 > 255) ? 255 : m_next + 4;
            else if (mean_exp > 136) m_next = (m_next - 4 < 16) ? 16 : m_next - 4;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if ({post_frame_vsync, post_frame_hsync, post_frame_de, mean_valid} !== 4'b0
            || img_y_out !== 8'd0 || frame_mean !== 8'd0 || cur_gain !== 8'd64) begin
            errors++;
            $display("FAIL %s got vs=%b hs=%b de=%b y=%0d mv=%b mean=%0d gain=%0d expected zeros and gain 64",
                     tag, post_frame_vsync, post_frame_hsync, post_frame_de, img_y_out,
                     mean_valid, frame_mean, cur_gain);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        vsync = 1'b1;
        hsync = 1'b0;
        de    = 1'b0;
        img_y = 8'd0;
        repeat (3) cyc;
        rst_n = 1'b1;
        m_next = 64;
        m_cur  = 64;
        @(negedge clk);
        check_reset_outputs("reset_state");
        cyc;
    endtask

    task automatic test_unity_step;
        run_frame(64, 8, 1'b0);
        run_frame(64, 8, 1'b0);
    endtask

    task automatic test_saturate_pixel;
        while (m_next != 128) run_frame(64, 8, 1'b0);
        run_frame(200, 8, 1'b0);
        run_frame(130, 8, 1'b0);
    endtask

    task automatic test_hysteresis;
        repeat (3) run_frame(130, 8, 1'b0);
        run_frame(136, 8, 1'b0);
        run_frame(89, 8, 1'b1);
        run_frame(137, 8, 1'b0);
        run_frame(88, 8, 1'b1);
        run_frame(130, 8, 1'b0);
    endtask

    task automatic test_truncated;
        run_frame(0, 5, 1'b0);
        run_frame(130, 8, 1'b0);
    endtask

    task automatic test_clamp;
        repeat (60) run_frame(0, 8, 1'b0);
        repeat (61) run_frame(255, 8, 1'b0);
    endtask

    task automatic test_reset_mid_frame;
        int roi_sum;
        roi_sum = 0;
        mv_cnt  = 0;
        vsync   = 1'b0;
        repeat (3) cyc;
        m_cur = m_next;
        for (int l = 0; l < 3; l++) drive_line(64, l, 1'b0, roi_sum);
        rst_n = 1'b0;
        cyc;
        rst_n  = 1'b1;
        m_next = 64;
        m_cur  = 64;
        @(negedge clk);
        check_reset_outputs("mid_frame_reset");
        cyc;
        for (int l = 3; l < 8; l++) drive_line(64, l, 1'b0, roi_sum);
        vsync = 1'b1;
        repeat (5) cyc;
        checks++;
        if (mv_cnt !== 0) begin
            errors++;
            $display("FAIL reset_frame_pulse got %0d expected 0", mv_cnt);
        end
        run_frame(64, 8, 1'b0);
        run_frame(64, 8, 1'b0);
    endtask

    initial begin
        test_reset;
        test_unity_step;
        test_saturate_pixel;
        test_hysteresis;
        test_truncated;
        test_clamp;
        test_reset_mid_frame;
        repeat (4) cyc;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pixels_missing got %0d outstanding expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
